fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the synchronous FIFO's single write port among `NUM_REQ` producers. It latches the winning producer's word, drives one FIFO write, and checks the FIFO's registered `wr_ack`/`overflow` response. It then returns a per-requester grant (accepted) or nack (dropped after retries). It sits between the producer agents and the FIFO write-side signals of the FIFO interface.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `FIFO_WIDTH`, 16: data word width; must match the FIFO.
- `MAX_RETRY`, 2: overflow retries per word before nack, 0..7.
- `IDX_W`, `$clog2(NUM_REQ)`: derived; do not override.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_REQ  producer i requests a write; held until `gnt[i]` or `nack[i]`.
- `req_data`  in  NUM_REQ*FIFO_WIDTH  word of producer i at bits [i*FIFO_WIDTH +: FIFO_WIDTH]; stable while `req[i]`.
- `gnt`  out  NUM_REQ  one-cycle pulse: word of producer i written and acked.
- `nack`  out  NUM_REQ  one-cycle pulse: word of producer i dropped.
- `grant_idx`  out  IDX_W  index of the producer currently being served.
- `busy`  out  1  high in WRITE and CHECK.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_data_in`  out  FIFO_WIDTH  FIFO write data.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr_ack`  in  1  FIFO write acknowledge, registered by the FIFO.
- `fifo_overflow`  in  1  FIFO overflow, registered by the FIFO.

## Operation
- State machine with three states:
  - **IDLE**: if `|req` and `!fifo_full`, pick the winner by round-robin. Latch its index into `grant_idx` and its word into `fifo_data_in`, then go to WRITE. Otherwise stay in IDLE.
  - **WRITE**: `fifo_wr_en`=1 for exactly this cycle. Always go to CHECK.
  - **CHECK**: `fifo_wr_en`=0; sample `fifo_wr_ack`/`fifo_overflow`.
    - `fifo_wr_ack`=1 (takes precedence if both are high): pulse `gnt[grant_idx]`, set `ptr` = `grant_idx`+1 mod NUM_REQ, clear the retry count, go to IDLE.
    - Otherwise, if retry count < MAX_RETRY: increment the retry count, go to IDLE. `ptr` is unchanged, so the same producer keeps top priority.
    - Otherwise: pulse `nack[grant_idx]`, advance `ptr` as for an ack, clear the retry count, go to IDLE.
    - Both flags low counts as an overflow.
- Round-robin rule: the winner is the first set `req` bit scanning upward from `ptr` and wrapping past NUM_REQ-1 to 0.
- Pulse timing: `gnt`/`nack` are registered and high during the IDLE cycle that follows CHECK. That IDLE cycle arbitrates normally.
- A producer that keeps `req` high after `gnt` must present its next word in the `gnt` cycle. That word is the next request.
- A `req[i]` drop without a `gnt`/`nack` is a protocol violation. Once latched, the word is still written.
- Reset values (`rst_n` low, asynchronous, any state): state=IDLE, `ptr`=0, retry count=0, `grant_idx`=0, `fifo_wr_en`=0, `fifo_data_in`=0, `gnt`=0, `nack`=0, `busy`=0.
  - Reset during WRITE deasserts `fifo_wr_en` immediately.
  - The in-flight word is abandoned with no `gnt`/`nack`; the producer re-requests.

## Timing
- `req` sampled at edge E0 → `fifo_wr_en` high in cycle E0..E1 → FIFO writes at E1 → `fifo_wr_ack` visible E1..E2 → sampled at E2 → `gnt` high E2..E3.
- Minimum 3 cycles per word: a new arbitration starts at E3, so `gnt` pulses recur at best every 3 cycles.
- `fifo_full` is sampled only in IDLE. Full rising while in WRITE/CHECK is resolved through the overflow/retry path.
- All outputs are registered; no combinational path from `req` or the FIFO inputs to any output.

## Test plan
- Single requester: `req`=4'b0001, word 16'hA5A5, FIFO empty → `fifo_wr_en` high in cycle 1 with `fifo_data_in`=A5A5; `gnt`=4'b0001 in cycle 3; FIFO holds A5A5.
- Fairness: all four `req` held high, distinct words → grant order 0,1,2,3,0; `gnt` every 3 cycles; FIFO contents follow the same order.
- Full blocking: FIFO filled to depth 8, `req[2]`=1 → `busy` stays 0 and no `fifo_wr_en` while full. One FIFO read → write issued, `gnt[2]` 3 cycles later.
- Overflow retry/nack (MAX_RETRY=2): `fifo_overflow` forced in every CHECK for `req[1]` → exactly 3 `fifo_wr_en` pulses, then `nack`=4'b0010; `ptr` advances to 2.
- Reset mid-operation: `rst_n` low in WRITE → `fifo_wr_en`, `busy`, `gnt`, `nack` drop to 0 the same cycle. After release, a pending `req[3]` restarts from `ptr`=0 and is granted.
- Back-to-back: `req[0]` held high with new words, `req[1]` high → grants alternate 0,1,0,1; `req[0]` is never granted twice in a row.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing a FIFO's single write port among NUM_REQ producers.
// Each served word costs three cycles: IDLE (arbitrate and latch), WRITE (one
// write strobe), CHECK (sample the FIFO's registered ack/overflow). Words that
// overflow are retried up to MAX_RETRY times before the producer is nacked.
// Every output is a register, so nothing combinational reaches the ports.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_RETRY  = 2,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            nack,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [2:0]       RETRY_LIM = 3'(MAX_RETRY);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        ptr_nxt;
    logic [2:0]              retry_cnt;
    logic [2:0]              retry_nxt;
    logic [IDX_W-1:0]        grant_idx_nxt;
    logic [FIFO_WIDTH-1:0]   data_nxt;
    logic                    wr_en_nxt;
    logic                    busy_nxt;
    logic [NUM_REQ-1:0]      gnt_nxt;
    logic [NUM_REQ-1:0]      nack_nxt;
    logic [IDX_W:0]          pick;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_vld;

    // First set request bit scanning upward from p with wrap-around.
    // Returns {found, index}. The downward loop lets the smallest offset win.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDX_W-1:0]   p);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(p) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (r[IDX_W'(j)]) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    // Pointer position just past the producer that was served.
    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
        return (g == LAST_IDX) ? '0 : g + 1'b1;
    endfunction

    assign pick    = rr_pick(req, ptr);
    assign win_vld = pick[IDX_W];
    assign win_idx = pick[IDX_W-1:0];

    // State and all output registers; reset abandons any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            retry_cnt    <= '0;
            grant_idx    <= '0;
            fifo_data_in <= '0;
            fifo_wr_en   <= 1'b0;
            busy         <= 1'b0;
            gnt          <= '0;
            nack         <= '0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            retry_cnt    <= retry_nxt;
            grant_idx    <= grant_idx_nxt;
            fifo_data_in <= data_nxt;
            fifo_wr_en   <= wr_en_nxt;
            busy         <= busy_nxt;
            gnt          <= gnt_nxt;
            nack         <= nack_nxt;
        end
    end

    // Next-state logic plus the next value of every registered output.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        retry_nxt     = retry_cnt;
        grant_idx_nxt = grant_idx;
        data_nxt      = fifo_data_in;
        wr_en_nxt     = 1'b0;
        busy_nxt      = 1'b0;
        gnt_nxt       = '0;
        nack_nxt      = '0;
        case (state)
            ST_IDLE: begin
                if (win_vld && !fifo_full) begin
                    grant_idx_nxt = win_idx;
                    data_nxt      = req_data[int'(win_idx) * FIFO_WIDTH +: FIFO_WIDTH];
                    wr_en_nxt     = 1'b1;
                    busy_nxt      = 1'b1;
                    state_nxt     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy_nxt  = 1'b1;
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
                // A missing ack is treated like an overflow, even if overflow is low too.
                if (fifo_wr_ack) begin
                    gnt_nxt   = NUM_REQ'(1) << grant_idx;
                    ptr_nxt   = ptr_after(grant_idx);
                    retry_nxt = '0;
                end else if (retry_cnt < RETRY_LIM) begin
                    retry_nxt = retry_cnt + 3'd1;
                end else begin
                    nack_nxt  = NUM_REQ'(1) << grant_idx;
                    ptr_nxt   = ptr_after(grant_idx);
                    retry_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a behavioural FIFO with injectable responses,
// producers that follow the request/grant handshake, a transaction-level
// reference model that fills expectation queues, and a monitor that checks
// every write strobe, grant/nack pulse and word read back from the FIFO.
module tb_fifo_wr_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int MR   = 2;
    localparam int IW   = 2;
    localparam int MAXW = 8;
    localparam int DEPTH = 8;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } att_t;

    typedef struct {
        int idx;
        bit g;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     gnt;
    logic [N-1:0]     nack;
    logic [IW-1:0]    grant_idx;
    logic             busy;
    logic             fifo_wr_en;
    logic [W-1:0]     fifo_data_in;
    logic             fifo_full;
    logic             fifo_wr_ack = 1'b0;
    logic             fifo_overflow = 1'b0;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .nack(nack), .grant_idx(grant_idx), .busy(busy),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expectation queues filled by the reference model
    att_t         exp_att[$];
    res_t         exp_res[$];
    logic [W-1:0] exp_store[$];
    int           kinds[$];

    // Behavioural FIFO: kind 0 = normal, 1 = overflow, 2 = no response, 3 = ack and overflow
    logic [W-1:0] fifo_q[$];
    logic [W-1:0] fm_word;
    int           fcount = 0;
    int           fm_k;
    bit           fm_rd;
    int           rd_pol = 0;
    bit           rd_once = 1'b0;

    assign fifo_full = (fcount >= DEPTH);

    always @(posedge clk) begin
        fm_rd = (rd_pol == 0) || (rd_pol == 1 && $urandom_range(1, 0) == 1) || rd_once;
        if (fm_rd && fifo_q.size() > 0) begin
            rd_once = 1'b0;
            fm_word = fifo_q.pop_front();
            if (exp_store.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fifo_rd: got extra word 0x%0h, want none", fm_word);
            end else begin
                check("fifo_rd", 32'(fm_word), 32'(exp_store.pop_front()));
            end
        end
        fifo_wr_ack   <= 1'b0;
        fifo_overflow <= 1'b0;
        if (fifo_wr_en) begin
            fm_k = (kinds.size() > 0) ? kinds.pop_front() : 0;
            case (fm_k)
                0: begin
                    if (fifo_q.size() < DEPTH) begin
                        fifo_q.push_back(fifo_data_in);
                        fifo_wr_ack <= 1'b1;
                    end else begin
                        fifo_overflow <= 1'b1;
                    end
                end
                1: fifo_overflow <= 1'b1;
                3: begin
                    fifo_q.push_back(fifo_data_in);
                    fifo_wr_ack   <= 1'b1;
                    fifo_overflow <= 1'b1;
                end
                default: ;
            endcase
        end
        fcount <= fifo_q.size();
    end

    // Producers
    logic [W-1:0] words[N][MAXW];
    int           nwords[N];
    int           pos[N];

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            if (pos[i] < nwords[i]) begin
                req[i] = 1'b1;
                req_data[i*W +: W] = words[i][pos[i]];
            end else begin
                req[i] = 1'b0;
            end
        end
    endtask

    task automatic drive_cycle();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (gnt[i] || nack[i]) pos[i]++;
        end
        drive_req();
    endtask

    task automatic clear_words();
        for (int i = 0; i < N; i++) begin
            nwords[i] = 0;
            pos[i] = 0;
        end
    endtask

    // Reference model at transaction level
    int model_ptr = 0;

    function automatic int rr_pick(input int p, input logic [N-1:0] pend);
        for (int off = 0; off < N; off++) begin
            if (pend[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    function automatic int gen_kind(input int mode);
        int r;
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        r = $urandom_range(99, 0);
        if (r < 60) return 0;
        if (r < 75) return 1;
        if (r < 90) return 2;
        return 3;
    endfunction

    task automatic predict(input int mode);
        int           cur[N];
        logic [N-1:0] pend;
        int           idx;
        int           tries;
        int           k;
        bit           ok;
        logic [W-1:0] w;
        for (int i = 0; i < N; i++) cur[i] = 0;
        forever begin
            for (int i = 0; i < N; i++) pend[i] = (cur[i] < nwords[i]);
            if (pend == '0) break;
            idx = rr_pick(model_ptr, pend);
            w = words[idx][cur[idx]];
            tries = 0;
            ok = 1'b0;
            while (!ok && tries <= MR) begin
                exp_att.push_back('{idx, w});
                k = gen_kind(mode);
                kinds.push_back(k);
                if (k == 0 || k == 3) ok = 1'b1;
                else tries++;
            end
            if (ok) begin
                exp_res.push_back('{idx, 1'b1});
                exp_store.push_back(w);
            end else begin
                exp_res.push_back('{idx, 1'b0});
            end
            cur[idx]++;
            model_ptr = (idx + 1) % N;
        end
    endtask

    // Monitor
    int           last_wr = 0;
    int           prev_res = -1;
    bit           chk_spacing = 1'b0;
    att_t         m_att;
    res_t         m_res;
    logic [N-1:0] m_vec;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fifo_wr_en) begin
                    if (exp_att.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected: got write 0x%0h idx %0d, want none", fifo_data_in, grant_idx);
                    end else begin
                        m_att = exp_att.pop_front();
                        check("wr_idx", 32'(grant_idx), 32'(m_att.idx));
                        check("wr_data", 32'(fifo_data_in), 32'(m_att.data));
                        check("wr_busy", 32'(busy), 32'd1);
                    end
                    last_wr = cyc;
                end
                if (gnt != '0 || nack != '0) begin
                    if (exp_res.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL res_unexpected: got gnt=%b nack=%b, want none", gnt, nack);
                    end else begin
                        m_res = exp_res.pop_front();
                        m_vec = N'(1) << m_res.idx;
                        check("gnt_vec", 32'(gnt), m_res.g ? 32'(m_vec) : 32'd0);
                        check("nack_vec", 32'(nack), m_res.g ? 32'd0 : 32'(m_vec));
                        check("res_busy", 32'(busy), 32'd0);
                        check("res_latency", 32'(cyc - last_wr), 32'd2);
                        if (chk_spacing && prev_res >= 0) check("gnt_spacing", 32'(cyc - prev_res), 32'd3);
                        prev_res = cyc;
                    end
                end
            end
        end
    end

    task automatic start_phase(input int mode);
        for (int i = 0; i < N; i++) pos[i] = 0;
        predict(mode);
        prev_res = -1;
        drive_req();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_att.size() > 0 || exp_res.size() > 0) && n < budget) begin
            drive_cycle();
            n++;
        end
        if (exp_att.size() > 0 || exp_res.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL phase_timeout: got %0d writes and %0d results outstanding, want 0",
                     exp_att.size(), exp_res.size());
            exp_att.delete();
            exp_res.delete();
            kinds.delete();
            clear_words();
            drive_req();
        end
    endtask

    int pre;
    int n;

    initial begin
        clear_words();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_nack", 32'(nack), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        check("rst_data", 32'(fifo_data_in), 32'd0);
        rst_n = 1'b1;
        drive_cycle();

        // single requester
        clear_words();
        words[0][0] = 16'hA5A5;
        nwords[0] = 1;
        start_phase(0);
        wait_done(50);

        // all four requesting, grants evenly spaced
        clear_words();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 2; j++) words[i][j] = W'(16'h1000 * (i + 1) + j);
            nwords[i] = 2;
        end
        chk_spacing = 1'b1;
        start_phase(0);
        wait_done(200);
        chk_spacing = 1'b0;

        // back-to-back between producers 0 and 1
        clear_words();
        for (int j = 0; j < 3; j++) begin
            words[0][j] = W'(16'h0A00 + j);
            words[1][j] = W'(16'h0B00 + j);
        end
        nwords[0] = 3;
        nwords[1] = 3;
        start_phase(0);
        wait_done(200);

        // persistent overflow for producer 1
        clear_words();
        words[1][0] = 16'hBEEF;
        nwords[1] = 1;
        start_phase(1);
        wait_done(100);

        // order after the nack
        clear_words();
        for (int i = 0; i < N; i++) begin
            words[i][0] = W'(16'hC000 + i);
            nwords[i] = 1;
        end
        start_phase(0);
        wait_done(200);

        // fill FIFO, then a request must wait for space
        rd_pol = 2;
        clear_words();
        for (int j = 0; j < MAXW; j++) words[0][j] = W'(16'hF000 + j);
        nwords[0] = MAXW;
        start_phase(0);
        wait_done(200);
        drive_cycle();
        check("fifo_full_after_fill", 32'(fifo_full), 32'd1);
        clear_words();
        words[2][0] = 16'h2222;
        nwords[2] = 1;
        start_phase(0);
        repeat (10) begin
            drive_cycle();
            check("busy_while_full", 32'(busy), 32'd0);
            check("wr_en_while_full", 32'(fifo_wr_en), 32'd0);
        end
        rd_once = 1'b1;
        wait_done(50);
        rd_pol = 0;
        repeat (12) drive_cycle();

        // reset while in WRITE
        clear_words();
        words[1][0] = 16'h1111;
        words[3][0] = 16'h3333;
        nwords[1] = 1;
        nwords[3] = 1;
        pre = rr_pick(model_ptr, 4'b1010);
        model_ptr = 0;
        for (int i = 0; i < N; i++) pos[i] = 0;
        predict(0);
        exp_att.push_front('{pre, words[pre][0]});
        prev_res = -1;
        drive_req();
        n = 0;
        do begin
            drive_cycle();
            n++;
        end while (!fifo_wr_en && n < 20);
        check("wr_before_reset", 32'(fifo_wr_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_nack", 32'(nack), 32'd0);
        drive_cycle();
        rst_n = 1'b1;
        wait_done(100);

        // randomized traffic with random FIFO responses and reads
        rd_pol = 1;
        repeat (8) begin
            clear_words();
            for (int i = 0; i < N; i++) begin
                nwords[i] = $urandom_range(4, 0);
                for (int j = 0; j < MAXW; j++) words[i][j] = W'($urandom);
            end
            start_phase(2);
            wait_done(1500);
        end

        // drain what is left
        rd_pol = 0;
        n = 0;
        while ((fcount > 0 || fifo_q.size() > 0) && n < 50) begin
            drive_cycle();
            n++;
        end
        check("fifo_drained", 32'(fifo_q.size()), 32'd0);
        check("store_left", 32'(exp_store.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
